bus_master: RTL and testbench
=============================

Name: bus_master

Overview:
- Initiator end of the two-phase valid/ready register bus that the team's slave register blocks respond on.
- Accepts single read/write commands from a local requester and runs them on the bus as an address phase followed by a data phase.
- Returns read data or write completion on a response channel.
- Sits between the local control logic and the bus; one outstanding transaction at a time.

Parameters:
- ADDR_W, 32, width of bus_addr and cmd_addr.
- DATA_W, 32, width of all data paths.
- TIMEOUT_CYCLES, 16, maximum wait cycles per bus phase before abort (used only with BUS_MASTER_TIMEOUT_EN). Legal range 2..65535.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  transaction aborted by timeout.
- bus_valid  out  1  master request on the bus.
- bus_read  out  1  read transaction.
- bus_write  out  1  write transaction; never high at the same time as bus_read.
- bus_addr  out  ADDR_W  transaction address.
- bus_write_data  out  DATA_W  write data.
- bus_ready  in  1  slave handshake.
- bus_read_data  in  DATA_W  slave read data.

Behaviour:
- Reset is synchronous: on a rising clk edge with reset=1, every output is forced to 0 and the FSM goes to IDLE. This holds from any state, including mid-transaction; any in-flight transaction is dropped with no response.
- Outputs at reset: cmd_ready, rsp_valid, rsp_err, bus_valid, bus_read and bus_write are 0. rsp_rdata, bus_addr and bus_write_data are 0.
- All outputs are driven from registers.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, capture cmd_addr, cmd_wdata and cmd_write into the bus_* registers, drive bus_read = !cmd_write and bus_write = cmd_write, set bus_valid=1, and go to ADDR. bus_valid is first high the cycle after acceptance.
  - ADDR: bus_valid=1. A handshake is bus_valid && bus_ready sampled at the rising edge. On handshake, go to DATA; bus_valid stays high, with no idle cycle between phases.
  - DATA: bus_valid=1. On handshake, capture bus_read_data into rsp_rdata for a read (0 for a write), drop bus_valid, bus_read and bus_write, set rsp_valid=1 and rsp_err=0, and go to RESP.
  - RESP: hold rsp_valid and the response fields stable until rsp_ready=1. Then clear rsp_valid and return to IDLE.
- cmd_ready is 0 in ADDR, DATA and RESP. A new command is accepted no earlier than the cycle after the response handshake.
- bus_addr, bus_write_data and the read/write flags are stable for the whole transaction.
- Minimum latency with bus_ready tied high: accept at cycle 0, ADDR handshake at cycle 1, DATA handshake at cycle 2, rsp_valid high at cycle 3.
- A bus_ready pulse seen while in IDLE or RESP is ignored.
- rsp_ready held high before rsp_valid rises has no effect until rsp_valid=1.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ADDR and on entry to DATA, and increments on each cycle in that phase without a handshake.
  - When the counter reaches TIMEOUT_CYCLES with no handshake, the master drops bus_valid, bus_read and bus_write, sets rsp_valid=1, rsp_err=1 and rsp_rdata=0, and goes to RESP.
  - A handshake on the same edge as the timeout wins: the transaction completes normally.
- Not defined: no counter is present, the master waits indefinitely, and rsp_err is tied to 0.

Test Plan:
- Read, bus_ready tied 1: cmd read at addr 0x10; slave returns 0xDEACBEFF -> bus_valid high for exactly 2 cycles with bus_read=1 and bus_addr=0x10; rsp_valid at cycle 3 with rsp_rdata=0xDEACBEFF and rsp_err=0.
- Write with slave stalls: cmd write addr 0x20, data 0x12345678; bus_ready low 3 cycles in ADDR and 2 in DATA -> bus fields stable throughout; rsp_valid after the DATA handshake with rsp_rdata=0.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable and cmd_ready=0 for all 5; cmd_ready=1 the cycle after rsp_ready rises.
- Back-to-back: cmd_valid held high with 2 queued reads -> the second is accepted only after the first response handshake; bus_read/bus_write never both 1.
- Reset mid-DATA: assert reset for 1 cycle during DATA -> next cycle all outputs 0 and cmd_ready=1; no rsp_valid is produced.
- BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready stuck 0 -> bus_valid drops after 4 wait cycles in ADDR; rsp_err=1 and rsp_rdata=0. Repeat with bus_ready rising exactly on the timeout edge -> normal completion with rsp_err=0.

Source files
------------

// File: rtl/bus_master.sv
// rtl/bus_master.sv - two-phase valid/ready register bus initiator, one outstanding transaction
// Optional per-phase wait timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_valid,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_read_q, bus_read_d;
  logic                bus_write_q, bus_write_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_write_data_q, bus_write_data_d;
  logic                handshake;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         wait_cnt_q, wait_cnt_d;
  logic                timeout;
`endif

  always_comb begin
    state_d          = state_q;
    cmd_ready_d      = cmd_ready_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    bus_valid_d      = bus_valid_q;
    bus_read_d       = bus_read_q;
    bus_write_d      = bus_write_q;
    bus_addr_d       = bus_addr_q;
    bus_write_data_d = bus_write_data_q;
    handshake        = bus_valid_q && bus_ready;
`ifdef BUS_MASTER_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d      = 1'b0;
          bus_valid_d      = 1'b1;
          bus_read_d       = !cmd_write;
          bus_write_d      = cmd_write;
          bus_addr_d       = cmd_addr;
          bus_write_data_d = cmd_wdata;
          state_d          = S_ADDR;
        end
      end
      S_ADDR: begin
        if (handshake) begin
          state_d = S_DATA;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      S_DATA: begin
        if (handshake) begin
          rsp_rdata_d = bus_read_q ? bus_read_data : '0;
          bus_valid_d = 1'b0;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          rsp_valid_d = 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BUS_MASTER_TIMEOUT_EN
    // Abort only reached when no handshake happened on this edge.
    if (timeout) begin
      bus_valid_d = 1'b0;
      bus_read_d  = 1'b0;
      bus_write_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      state_d     = S_RESP;
    end
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cmd_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      bus_valid_q      <= 1'b0;
      bus_read_q       <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_addr_q       <= '0;
      bus_write_data_q <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      rsp_err_q        <= 1'b0;
      wait_cnt_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      bus_valid_q      <= bus_valid_d;
      bus_read_q       <= bus_read_d;
      bus_write_q      <= bus_write_d;
      bus_addr_q       <= bus_addr_d;
      bus_write_data_q <= bus_write_data_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      rsp_err_q        <= rsp_err_d;
      wait_cnt_q       <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign bus_valid      = bus_valid_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_addr       = bus_addr_q;
  assign bus_write_data = bus_write_data_q;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign rsp_err        = rsp_err_q;
`else
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - directed scoreboard bench for bus_master (timeout cases under BUS_MASTER_TIMEOUT_EN)
module tb_bus_master;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_valid, bus_read, bus_write, bus_ready;
  logic [31:0] bus_addr, bus_write_data, bus_read_data;
  logic [31:0] rd_key;
  logic        mon_en = 1'b0;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_read(bus_read), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data)
  );

  always #5 clk = ~clk;

  // Slave returns a per-address pattern so each read has a distinct expected value.
  assign bus_read_data = bus_addr ^ rd_key;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) check("rw_exclusive", {63'd0, bus_read & bus_write}, 64'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit keep);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    step();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    while (rsp_valid !== 1'b1 && n < 50) begin
      check({tag, "_busy_cmd_ready"}, cmd_ready, 0);
      step();
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, rsp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        check({tag, "_hold_valid"}, rsp_valid, 1);
        check({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        step();
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, rsp_valid, 0);
    check({tag, "_cmd_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_ready = 1'b0; rd_key = 32'hDEAC_BEEF;
    step(); step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_rw", {bus_read, bus_write}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_write_data, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // bus_ready pulse while idle is ignored
    bus_ready = 1'b1;
    step();
    check("idle_ready_bus_valid", bus_valid, 0);
    check("idle_ready_rsp_valid", rsp_valid, 0);

    // Read at minimum latency; 0x10 ^ key = 0xDEACBEFF
    sb.push_back('{1'b0, 32'hDEAC_BEFF});
    issue(1'b0, 32'h10, 32'h0, 1'b0);
    check("rd_c1_bus_valid", bus_valid, 1);
    check("rd_c1_bus_read", bus_read, 1);
    check("rd_c1_bus_write", bus_write, 0);
    check("rd_c1_bus_addr", bus_addr, 32'h10);
    check("rd_c1_cmd_ready", cmd_ready, 0);
    step();
    check("rd_c2_bus_valid", bus_valid, 1);
    step();
    check("rd_c3_bus_valid", bus_valid, 0);
    check("rd_c3_rsp_valid", rsp_valid, 1);
    get_rsp("rd", 0);

    // Write with slave stalls in both phases
    bus_ready = 1'b0;
    sb.push_back('{1'b0, 32'h0});
    issue(1'b1, 32'h20, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("wr_addr_valid", bus_valid, 1);
      check("wr_addr_flags", {bus_read, bus_write}, 2'b01);
      check("wr_addr_addr", bus_addr, 32'h20);
      check("wr_addr_wdata", bus_write_data, 32'h1234_5678);
      step();
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wr_data_valid", bus_valid, 1);
      check("wr_data_flags", {bus_read, bus_write}, 2'b01);
      check("wr_data_addr", bus_addr, 32'h20);
      check("wr_data_wdata", bus_write_data, 32'h1234_5678);
      check("wr_data_no_rsp", rsp_valid, 0);
      step();
    end
    bus_ready = 1'b1;
    step();
    get_rsp("wr", 0);

    // Response backpressure for 5 cycles
    sb.push_back('{1'b0, 32'h30 ^ rd_key});
    issue(1'b0, 32'h30, 32'h0, 1'b0);
    get_rsp("bp", 5);

    // Back-to-back with cmd_valid held high
    rd_key = 32'hA5A5_0000;
    sb.push_back('{1'b0, 32'h40 ^ 32'hA5A5_0000});
    issue(1'b0, 32'h40, 32'h0, 1'b1);
    cmd_addr = 32'h44;
    sb.push_back('{1'b0, 32'h44 ^ 32'hA5A5_0000});
    get_rsp("b2b_first", 0);
    step();
    cmd_valid = 1'b0;
    check("b2b_second_addr", bus_addr, 32'h44);
    check("b2b_second_valid", bus_valid, 1);
    get_rsp("b2b_second", 0);

    // rsp_ready already high before rsp_valid rises
    rsp_ready = 1'b1;
    sb.push_back('{1'b0, 32'h60 ^ 32'hA5A5_0000});
    issue(1'b0, 32'h60, 32'h0, 1'b0);
    check("early_ready_no_rsp_yet", rsp_valid, 0);
    get_rsp("early_ready", 0);

    // Reset during DATA drops the transaction
    bus_ready = 1'b0;
    issue(1'b0, 32'h50, 32'h0, 1'b0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check("mid_in_data", bus_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_outputs",
          {cmd_ready, rsp_valid, rsp_err, bus_valid, bus_read, bus_write}, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    bus_ready = 1'b1;
    step();
    check("mid_rst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_rsp", rsp_valid, 0);
      check("mid_rst_no_bus", bus_valid, 0);
      step();
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    // Stuck slave: abort after 4 wait cycles in ADDR
    bus_ready = 1'b0;
    sb.push_back('{1'b1, 32'h0});
    issue(1'b0, 32'h70, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("to_waiting_valid", bus_valid, 1);
      check("to_waiting_no_rsp", rsp_valid, 0);
      step();
    end
    check("to_bus_dropped", {bus_valid, bus_read, bus_write}, 0);
    get_rsp("to_abort", 0);

    // Handshake on the timeout edge completes normally
    sb.push_back('{1'b0, 32'h74 ^ 32'hA5A5_0000});
    issue(1'b0, 32'h74, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    bus_ready = 1'b1;
    step();
    check("to_race_in_data", bus_valid, 1);
    step();
    get_rsp("to_race", 0);
`endif

    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
